// File: rtl/control_pkg.sv
// control_pkg
// Shared definitions for the microsequencer slice.
//   STATE_W    : width of the control-state / microprogram store address
//   COND_W     : width of the condition vector presented to the sequencer
//   n_sel_e    : next-address select encoding (microword bits N2-N0)
//   COND_*     : bit positions of the named conditions inside cond_in
package control_pkg;

  localparam int STATE_W = 8;
  localparam int COND_W  = 8;

  typedef enum logic [2:0] {
    NS_ENC   = 3'b000,
    NS_FETCH = 3'b001,
    NS_CR    = 3'b010,
    NS_INC   = 3'b011,
    NS_CR_C  = 3'b100,
    NS_ENC_C = 3'b101,
    NS_WAIT  = 3'b110,
    NS_RET   = 3'b111
  } n_sel_e;

  localparam int COND_MOC        = 0;
  localparam int COND_ARM_PASS   = 1;
  localparam int COND_SHIFT_ZERO = 2;
  localparam int COND_LSM_DONE   = 3;

endpackage

// File: rtl/useq_cond_sel.sv
// useq_cond_sel
// Combinational condition select: picks one bit of the condition vector and
// optionally inverts it, producing the single branch condition c.
// Ports:
//   cond_in : condition vector ([0] MOC, [1] cond-pass, [2] shifter-zero, [3] LSM-done)
//   s_sel   : condition select (microword S2-S0)
//   inv     : condition invert (microword INV)
//   c       : selected, optionally inverted condition
module useq_cond_sel
  import control_pkg::*;
(
  input  logic [COND_W-1:0] cond_in,
  input  logic [2:0]        s_sel,
  input  logic              inv,
  output logic              c
);

  always_comb begin
    c = cond_in[s_sel] ^ inv;
  end

endmodule

// File: rtl/microsequencer.sv
// microsequencer
// Microprogram sequencer: each cycle selects the next control-store address
// from the encoder, the microword target, a return register, or state+1,
// under control of the current microword. Supports a one-level
// microsubroutine call/return, wait-hold on a condition, and a bus-timeout
// trap when a wait-hold lasts too long.
// Ports:
//   clk, rst_n : single clock, asynchronous active-low reset
//   n_sel      : next-address select (microword N2-N0)
//   inv        : condition invert (microword INV)
//   mi         : microsubroutine call flag (microword MI)
//   s_sel      : condition select (microword S2-S0)
//   cr_addr    : microword target address (CR7-CR0)
//   enc_addr   : decode entry state from the instruction encoder
//   cond_in    : condition vector
//   state      : current state = microprogram store address
//   trap       : one-cycle pulse when the bus-timeout trap is taken
//   busy_wait  : high while the current cycle is a wait-hold cycle
module microsequencer #(
  parameter int unsigned        STATE_W     = control_pkg::STATE_W,
  parameter logic [STATE_W-1:0] FETCH_STATE = STATE_W'(1),
  parameter logic [7:0]         TIMEOUT     = 8'd255,
  parameter logic [STATE_W-1:0] TRAP_STATE  = STATE_W'(46)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [2:0]                     n_sel,
  input  logic                           inv,
  input  logic                           mi,
  input  logic [2:0]                     s_sel,
  input  logic [STATE_W-1:0]             cr_addr,
  input  logic [STATE_W-1:0]             enc_addr,
  input  logic [control_pkg::COND_W-1:0] cond_in,
  output logic [STATE_W-1:0]             state,
  output logic                           trap,
  output logic                           busy_wait
);

  logic [STATE_W-1:0] state_q, state_d;
  logic [STATE_W-1:0] ret_q, ret_d;
  logic [7:0]         wait_cnt_q, wait_cnt_d;
  logic [STATE_W-1:0] state_inc;
  logic               c;
  logic               timeout_hit;

  useq_cond_sel u_cond_sel (
    .cond_in (cond_in),
    .s_sel   (s_sel),
    .inv     (inv),
    .c       (c)
  );

  always_comb begin
    state_inc   = state_q + STATE_W'(1);
    busy_wait   = (n_sel == control_pkg::NS_WAIT) && c;
    // The trap fires on the wait cycle that would push the count to TIMEOUT.
    timeout_hit = busy_wait && (wait_cnt_q == TIMEOUT - 8'd1);

    state_d = state_inc;
    case (n_sel)
      control_pkg::NS_ENC:   state_d = enc_addr;
      control_pkg::NS_FETCH: state_d = FETCH_STATE;
      control_pkg::NS_CR:    state_d = cr_addr;
      control_pkg::NS_INC:   state_d = state_inc;
      control_pkg::NS_CR_C:  state_d = c ? cr_addr : state_inc;
      control_pkg::NS_ENC_C: state_d = c ? enc_addr : state_inc;
      control_pkg::NS_WAIT:  state_d = c ? state_q : state_inc;
      control_pkg::NS_RET:   state_d = ret_q;
      default:               state_d = state_inc;
    endcase

    // A call always captures the return point, even when it coincides with a
    // return; the return above has already consumed the old ret_q.
    ret_d = mi ? state_inc : ret_q;

    wait_cnt_d = 8'd0;
    if (timeout_hit) begin
      state_d    = TRAP_STATE;
      wait_cnt_d = 8'd0;
    end else if (busy_wait) begin
      wait_cnt_d = (wait_cnt_q == TIMEOUT) ? wait_cnt_q : wait_cnt_q + 8'd1;
    end

    // Gated so the pulse stays low while reset is held.
    trap  = timeout_hit && rst_n;
    state = state_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= '0;
      ret_q      <= '0;
      wait_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule
